vec_wb_buffer: RTL
==================

// Module: vec_wb_buffer
// PURPOSE
//  Writeback buffer directly downstream of the vector execute stage.
//  - Captures per-lane results (lane enables, dst reg, data, ticket) from the execute stage.
//  - Queues them in a small in-order FIFO and drains one entry per cycle to the VRF write
//    port under the VRF's ready back-pressure.
//  - Reports each retired ticket to the vector scoreboard.
//  - Gives the execute stage early back-pressure, because execute has a 1-cycle registered output.
// PARAMETERS
//  DATA_WIDTH          32  per-lane element width
//  VECTOR_LANES        8   lanes per entry
//  VECTOR_TICKET_BITS  4   ticket width
//  DEPTH               4   FIFO entries; power of 2, >=2
// PORTS
//  clk              in   1                  clock, rising edge
//  rst              in   1                  asynchronous, active-high reset
//  flush            in   1                  sync clear of all queued entries
//  wb_en_i          in   VECTOR_LANES       lane write enables from execute
//  wb_addr_i        in   5                  destination vreg
//  wb_data_i        in   LANES*DATA_WIDTH   lane results
//  wb_ticket_i      in   TICKET_BITS        instruction ticket
//  almost_full_o    out  1                  to execute/issue: stop issuing
//  vrf_wr_en_o      out  VECTOR_LANES       VRF lane write enables
//  vrf_wr_addr_o    out  5                  VRF write address
//  vrf_wr_data_o    out  LANES*DATA_WIDTH   VRF write data
//  vrf_ready_i      in   1                  VRF accepts the write this cycle
//  tk_done_valid_o  out  1                  ticket retired (1-cycle pulse)
//  tk_done_o        out  TICKET_BITS        retired ticket
//  count_o          out  $clog2(DEPTH)+1    occupancy
//  overflow_o       out  1                  sticky: push dropped while full
// BEHAVIOUR
//  - Reset: all outputs 0; pointers/count 0; storage contents don't-care.
//  - push = |wb_en_i. There is no valid/ready pair; execute relies on almost_full_o.
//  - pop = (count!=0) & vrf_ready_i.
//  - vrf_wr_en_o = head.en when count!=0, else 0.
//  - vrf_wr_addr_o / vrf_wr_data_o come from the registered head entry.
//    - No bypass: min latency push->VRF write is 1 cycle.
//  - almost_full_o = (count >= DEPTH-1), registered-count based. This slack absorbs the 1
//    result already in flight in execute.
//  - Push accepted when count<DEPTH, or when count==DEPTH and pop in the same cycle.
//  - Otherwise the push is dropped and overflow_o sets. overflow_o clears only on rst, not flush.
//  - Simultaneous push+pop: count unchanged; both pointers advance.
//    - Also legal at count==0? No: pop requires count!=0, so at 0 the push simply lands.
//  - Pointers: log2(DEPTH) bits, natural wrap. count is tracked separately, so full/empty is unambiguous.
//  - tk_done: registered. Cycle after a pop, tk_done_valid_o=1 and tk_done_o=popped ticket.
//    Tickets retire strictly in push order.
//  - flush (priority over push/pop):
//    - next cycle count=0 and pointers=0;
//    - a same-cycle push is dropped, with no overflow;
//    - a same-cycle pop does not occur: VRF write en forced 0 that cycle, no tk_done.
//  - An entry with wb_en_i partially set keeps its exact lane mask; disabled lanes are never written.
//  - vrf_ready_i low: head held stable, outputs unchanged until accepted.
// STRUCTURE
//  - Shared vector package (with to_vector_exec):
//    - typedef vwb_entry_t {en[LANES], addr[5], data[LANES][DW], ticket};
//    - localparam VREG_ADDR_BITS=5.
//  - One sub-module, vec_wb_fifo_ctrl: pointers, count, push/pop/flush arbitration, full/almost_full.
//  - Storage array and tk_done register live in the top.
// TESTING
//  1. Reset:
//     - assert rst mid-traffic -> all outputs 0 immediately;
//     - count_o=0 after release; overflow_o=0.
//  2. Single push, addr=7, en=8'hFF, ticket=3, vrf_ready=1:
//     - cycle+1: vrf_wr_en=FF, addr=7;
//     - cycle+2: tk_done_valid=1, tk_done=3.
//  3. Stall/back-pressure:
//     - vrf_ready=0, push 3 entries -> almost_full_o=1 at count=3;
//     - push 4th -> count=4;
//     - raise ready -> tickets drain in order 0,1,2,3, one per cycle.
//  4. Full + push+pop, count=4, ready=1 -> push accepted, count stays 4, overflow_o=0.
//  5. Full, ready=0, push -> dropped; overflow_o=1 and stays after flush.
//  6. Flush:
//     - flush with count=3 and push in same cycle -> count=0;
//     - no VRF write or tk_done that cycle;
//     - next push retires normally.
//  - Partial mask en=8'h05 -> only lanes 0 and 2 written.

Source files
------------

// File: rtl/vec_wb_buffer_pkg.sv
// Shared vector datapath package: register-file address width and the
// default-configuration writeback entry layout.
`default_nettype none

package vec_wb_buffer_pkg;

  localparam int VREG_ADDR_BITS  = 5;
  localparam int VEC_LANES       = 8;
  localparam int VEC_DATA_WIDTH  = 32;
  localparam int VEC_TICKET_BITS = 4;

  typedef struct packed {
    logic [VEC_LANES-1:0]                     en;
    logic [VREG_ADDR_BITS-1:0]                addr;
    logic [VEC_LANES-1:0][VEC_DATA_WIDTH-1:0] data;
    logic [VEC_TICKET_BITS-1:0]               ticket;
  } vwb_entry_t;

endpackage

`default_nettype wire

// File: rtl/vec_wb_fifo_ctrl.sv
// Pointer/occupancy controller for the writeback FIFO: push/pop/flush
// arbitration, occupancy thresholds and the sticky overflow flag.
`default_nettype none

module vec_wb_fifo_ctrl #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_req,
  input  logic             vrf_ready,
  output logic             push_ok,
  output logic             pop_ok,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             overflow
);

  logic empty;
  logic full;

  always_comb begin
    empty       = (count == '0);
    full        = (count == CNT_W'(DEPTH));
    almost_full = (count >= CNT_W'(DEPTH - 1));
    pop_ok      = !flush && !empty && vrf_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    push_ok     = !flush && push_req && (!full || pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vec_wb_buffer.sv
// Vector writeback buffer: in-order queue of execute results drained to the
// VRF write port under back-pressure, with per-entry ticket retirement.
`default_nettype none

module vec_wb_buffer
  import vec_wb_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = VEC_DATA_WIDTH,
  parameter int VECTOR_LANES       = VEC_LANES,
  parameter int VECTOR_TICKET_BITS = VEC_TICKET_BITS,
  parameter int DEPTH              = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [VECTOR_LANES-1:0]            wb_en_i,
  input  logic [VREG_ADDR_BITS-1:0]          wb_addr_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] wb_data_i,
  input  logic [VECTOR_TICKET_BITS-1:0]      wb_ticket_i,
  output logic                               almost_full_o,
  output logic [VECTOR_LANES-1:0]            vrf_wr_en_o,
  output logic [VREG_ADDR_BITS-1:0]          vrf_wr_addr_o,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] vrf_wr_data_o,
  input  logic                               vrf_ready_i,
  output logic                               tk_done_valid_o,
  output logic [VECTOR_TICKET_BITS-1:0]      tk_done_o,
  output logic [$clog2(DEPTH):0]             count_o,
  output logic                               overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic                               push_ok;
  logic                               pop_ok;
  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic                               head_valid;

  logic [VECTOR_LANES-1:0]            en_mem   [DEPTH];
  logic [VREG_ADDR_BITS-1:0]          addr_mem [DEPTH];
  logic [VECTOR_LANES*DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [VECTOR_TICKET_BITS-1:0]      tk_mem   [DEPTH];

  vec_wb_fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push_req    (|wb_en_i),
    .vrf_ready   (vrf_ready_i),
    .push_ok     (push_ok),
    .pop_ok      (pop_ok),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count_o),
    .almost_full (almost_full_o),
    .overflow    (overflow_o)
  );

  // Payload storage needs no reset; validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      en_mem[wr_ptr]   <= wb_en_i;
      addr_mem[wr_ptr] <= wb_addr_i;
      data_mem[wr_ptr] <= wb_data_i;
      tk_mem[wr_ptr]   <= wb_ticket_i;
    end
  end

  always_comb begin
    head_valid    = (count_o != '0);
    vrf_wr_en_o   = (head_valid && !flush) ? en_mem[rd_ptr] : '0;
    vrf_wr_addr_o = head_valid ? addr_mem[rd_ptr] : '0;
    vrf_wr_data_o = head_valid ? data_mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tk_done_valid_o <= 1'b0;
      tk_done_o       <= '0;
    end else begin
      tk_done_valid_o <= pop_ok;
      if (pop_ok) tk_done_o <= tk_mem[rd_ptr];
    end
  end

endmodule

`default_nettype wire
